// File: rtl/multiplier_datapath.sv
// Shift-and-add multiplier datapath: A/C/Q/M registers and step counter driven by sequencer commands.
// Optional protocol checker enabled by defining MULT_DP_PROTOCOL_CHECK_EN; otherwise err is tied low.
module multiplier_datapath #(
    parameter int n = 4
) (
    input  logic           clock,
    input  logic           n_reset,
    input  logic           reset,
    input  logic           add_shift,
    input  logic           shift,
    input  logic [n-1:0]   multiplicand,
    input  logic [n-1:0]   multiplier,
    output logic           Q0,
    output logic [2*n-1:0] product,
    output logic           product_valid,
    output logic           err
);

    localparam int              CW       = $clog2(n + 1);
    localparam logic [CW-1:0]   CNT_DONE = CW'(n);

    logic [n-1:0]  a_q, a_d;
    logic [n-1:0]  q_q, q_d;
    logic [n-1:0]  m_q, m_d;
    logic          c_q, c_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          valid_q, valid_d;
    logic [n:0]    sum;
    logic          done;

    assign sum  = {1'b0, a_q} + {1'b0, m_q};
    assign done = (cnt_q == CNT_DONE);

    always_comb begin
        a_d   = a_q;
        q_d   = q_q;
        m_d   = m_q;
        c_d   = c_q;
        cnt_d = cnt_q;
        if (reset) begin
            m_d   = multiplicand;
            q_d   = multiplier;
            a_d   = '0;
            c_d   = 1'b0;
            cnt_d = '0;
        end else if (add_shift && !done) begin
            // The add carry lands directly in A's MSB, so C never holds a value across edges.
            a_d   = {sum[n], sum[n-1:1]};
            q_d   = {sum[0], q_q[n-1:1]};
            c_d   = 1'b0;
            cnt_d = cnt_q + 1'b1;
        end else if (shift && !done) begin
            a_d   = {c_q, a_q[n-1:1]};
            q_d   = {a_q[0], q_q[n-1:1]};
            c_d   = 1'b0;
            cnt_d = cnt_q + 1'b1;
        end
        // cnt_d is zero on a reset command, so this also clears valid there.
        valid_d = (cnt_d == CNT_DONE);
    end

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            a_q     <= a_d;
            q_q     <= q_d;
            m_q     <= m_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    assign Q0            = q_q[0];
    assign product       = {a_q, q_q};
    assign product_valid = valid_q;

`ifdef MULT_DP_PROTOCOL_CHECK_EN
    logic err_q, err_d;
    logic violation;

    assign violation = (add_shift && shift)
                     || ((add_shift || shift) && done)
                     || (add_shift && !q_q[0]);

    always_comb begin
        err_d = err_q;
        if (reset) begin
            err_d = 1'b0;
        end else if (violation) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_multiplier_datapath.sv
// Directed bench for multiplier_datapath (n=4) with hand-computed products and Q0 sequences.
module tb_multiplier_datapath;

`ifdef MULT_DP_PROTOCOL_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       n_reset = 1'b0;
    logic       reset = 1'b0;
    logic       add_shift = 1'b0;
    logic       shift = 1'b0;
    logic [3:0] multiplicand = '0;
    logic [3:0] multiplier = '0;
    logic       Q0;
    logic [7:0] product;
    logic       product_valid;
    logic       err;

    int n_cmp = 0;
    int n_bad = 0;

    multiplier_datapath #(.n(4)) dut (
        .clock        (clock),
        .n_reset      (n_reset),
        .reset        (reset),
        .add_shift    (add_shift),
        .shift        (shift),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .Q0           (Q0),
        .product      (product),
        .product_valid(product_valid),
        .err          (err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of commands, sample 1 time unit after the edge.
    task automatic cycle(input logic r, input logic as, input logic sh);
        reset = r; add_shift = as; shift = sh;
        @(posedge clock);
        #1;
        reset = 1'b0; add_shift = 1'b0; shift = 1'b0;
    endtask

    task automatic load(input logic [3:0] mc, input logic [3:0] mp);
        multiplicand = mc; multiplier = mp;
        cycle(1'b1, 1'b0, 1'b0);
        check("load_q0", Q0, mp[0]);
        check("load_valid", product_valid, 1'b0);
    endtask

    // cmds[i]=1 issues add_shift for step i, else shift.
    task automatic run_vec(input string tag, input logic [3:0] mc, input logic [3:0] mp,
                           input logic [3:0] cmds, input logic [7:0] exp_p);
        load(mc, mp);
        for (int i = 0; i < 4; i++) begin
            check({tag, "_q0"}, Q0, mp[i]);
            check({tag, "_valid_early"}, product_valid, 1'b0);
            cycle(1'b0, cmds[i], !cmds[i]);
        end
        check({tag, "_product"}, product, exp_p);
        check({tag, "_valid"}, product_valid, 1'b1);
        check({tag, "_err"}, err, 1'b0);
    endtask

    initial begin
        #2;
        check("rst_product", product, 8'h00);
        check("rst_valid", product_valid, 1'b0);
        check("rst_q0", Q0, 1'b0);
        check("rst_err", err, 1'b0);
        @(negedge clock);
        n_reset = 1'b1;
        cycle(1'b0, 1'b0, 1'b0);
        check("idle_product", product, 8'h00);

        run_vec("basic", 4'd13, 4'd11, 4'b1011, 8'h8F);
        run_vec("carry", 4'd15, 4'd15, 4'b1111, 8'hE1);
        run_vec("zero",  4'd9,  4'd0,  4'b0000, 8'h00);

        // Overrun: extra shifts after completion must not disturb the result.
        run_vec("sat", 4'd7, 4'd5, 4'b0101, 8'h23);
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1);
        check("sat_product", product, 8'h23);
        check("sat_valid", product_valid, 1'b1);
        check("sat_err", err, ERR_EN);
        cycle(1'b0, 1'b0, 1'b0);
        check("sat_hold", product, 8'h23);

        // Reset command clears a sticky err and restarts the counter.
        load(4'd3, 4'd1);
        check("sim_err_cleared", err, 1'b0);
        cycle(1'b0, 1'b1, 1'b1);
        check("sim_product", product, 8'h18);
        check("sim_err", err, ERR_EN);
        check("sim_valid", product_valid, 1'b0);

        // Async reset mid-operation, observed before the next edge.
        load(4'd13, 4'd11);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        check("mid_product", product, 8'h9E);
        @(negedge clock);
        n_reset = 1'b0;
        #1;
        check("arst_product", product, 8'h00);
        check("arst_q0", Q0, 1'b0);
        check("arst_valid", product_valid, 1'b0);
        check("arst_err", err, 1'b0);
        @(negedge clock);
        n_reset = 1'b1;
        cycle(1'b0, 1'b1, 1'b0);
        check("arst_after_product", product, 8'h00);
        check("arst_after_valid", product_valid, 1'b0);

        run_vec("post", 4'd3, 4'd3, 4'b0011, 8'h09);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
